// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package reg_file_mp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int BYTE_WIDTH     = 8;

  // Number of byte lanes in a word of the given width.
  function automatic int num_bytes(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file.
interface reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [NUM_WRITE-1:0]            WRITE_ENABLE;
  logic [NUM_WRITE*ADDR_WIDTH-1:0] WRITE_ADDRESS;
  logic [NUM_WRITE*DATA_WIDTH-1:0] WRITE_DATA;
  logic [NUM_WRITE*BYTES-1:0]      WRITE_BYTE_EN;
  logic [NUM_READ*ADDR_WIDTH-1:0]  READ_ADDRESS;
  logic [NUM_READ*DATA_WIDTH-1:0]  READ_DATA;
  logic [NUM_READ-1:0]             READ_BUSY;
  logic                            RESERVE_ENABLE;
  logic [ADDR_WIDTH-1:0]           RESERVE_ADDRESS;

  modport master (
    output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, WRITE_BYTE_EN,
    output READ_ADDRESS, RESERVE_ENABLE, RESERVE_ADDRESS,
    input  READ_DATA, READ_BUSY
  );

  modport slave (
    input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, WRITE_BYTE_EN,
    input  READ_ADDRESS, RESERVE_ENABLE, RESERVE_ADDRESS,
    output READ_DATA, READ_BUSY
  );

endinterface

// File: rtl/reg_file_mp_read_port.sv
// One combinational read port: array lookup, byte-merge bypass of this
// cycle's writes, zero-register masking and busy lookup.
module reg_file_mp_read_port
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1,
  localparam int BYTES     = DATA_WIDTH / BYTE_WIDTH,
  localparam int DEPTH     = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0]           read_address,
  input  logic [DEPTH*DATA_WIDTH-1:0]     array_data,
  input  logic [NUM_WRITE-1:0]            write_enable,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] write_address,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data,
  input  logic [NUM_WRITE*BYTES-1:0]      write_byte_en,
  input  logic [DEPTH-1:0]                busy,
  output logic [DATA_WIDTH-1:0]           read_data,
  output logic                            read_busy
);

  logic is_zero_s;

  // Stored word, overlaid byte-by-byte with enabled write lanes; later
  // (higher-index) ports overwrite earlier ones so the conflict rule matches
  // the array update.
  always_comb begin
    is_zero_s = (ZERO_REG != 0) && (read_address == {ADDR_WIDTH{1'b0}});
    read_data = array_data[int'(read_address)*DATA_WIDTH +: DATA_WIDTH];
    for (int k = 0; k < NUM_WRITE; k++) begin
      for (int b = 0; b < BYTES; b++) begin
        read_data[b*BYTE_WIDTH +: BYTE_WIDTH] =
          ((BYPASS != 0) && write_enable[k] && write_byte_en[k*BYTES+b] &&
           (write_address[k*ADDR_WIDTH +: ADDR_WIDTH] == read_address))
          ? write_data[k*DATA_WIDTH + b*BYTE_WIDTH +: BYTE_WIDTH]
          : read_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    read_data = is_zero_s ? {DATA_WIDTH{1'b0}} : read_data;
    read_busy = is_zero_s ? 1'b0 : busy[read_address];
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with byte enables, write-to-read
// bypass and a per-register busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_mp_if.slave bus
);

  localparam int BYTES = num_bytes(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]          mem_r [DEPTH];
  logic [DEPTH-1:0]               busy_r;
  logic [DEPTH-1:0]               busy_next_s;
  logic [DEPTH*DATA_WIDTH-1:0]    mem_flat_s;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_data_s;
  logic [NUM_READ-1:0]            rd_busy_s;

  // Byte-lane array update; ports are applied in index order so the
  // higher-index port wins any lane both ports enable.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_r[r] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (bus.WRITE_ENABLE[k] &&
            !((ZERO_REG != 0) &&
              (bus.WRITE_ADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH] == {ADDR_WIDTH{1'b0}}))) begin
          for (int b = 0; b < BYTES; b++) begin
            if (bus.WRITE_BYTE_EN[k*BYTES+b]) begin
              mem_r[bus.WRITE_ADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH]][b*BYTE_WIDTH +: BYTE_WIDTH]
                <= bus.WRITE_DATA[k*DATA_WIDTH + b*BYTE_WIDTH +: BYTE_WIDTH];
            end
          end
        end
      end
    end
  end

  // Scoreboard next state: writes retire producers, then a reserve (the
  // newer producer) re-marks its target; register 0 is never busy.
  always_comb begin
    busy_next_s = busy_r;
    for (int k = 0; k < NUM_WRITE; k++) begin
      busy_next_s[bus.WRITE_ADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH]] =
        (bus.WRITE_ENABLE[k] && (|bus.WRITE_BYTE_EN[k*BYTES +: BYTES]))
        ? 1'b0 : busy_next_s[bus.WRITE_ADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
    busy_next_s[bus.RESERVE_ADDRESS] =
      bus.RESERVE_ENABLE ? 1'b1 : busy_next_s[bus.RESERVE_ADDRESS];
    busy_next_s[0] = (ZERO_REG != 0) ? 1'b0 : busy_next_s[0];
  end

  // Scoreboard register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Present the array as one flat vector to the read ports.
  always_comb begin
    mem_flat_s = {(DEPTH*DATA_WIDTH){1'b0}};
    for (int r = 0; r < DEPTH; r++) begin
      mem_flat_s[r*DATA_WIDTH +: DATA_WIDTH] = mem_r[r];
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    reg_file_mp_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_WRITE  (NUM_WRITE),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_read_port (
      .read_address  (bus.READ_ADDRESS[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .array_data    (mem_flat_s),
      .write_enable  (bus.WRITE_ENABLE),
      .write_address (bus.WRITE_ADDRESS),
      .write_data    (bus.WRITE_DATA),
      .write_byte_en (bus.WRITE_BYTE_EN),
      .busy          (busy_r),
      .read_data     (rd_data_s[i*DATA_WIDTH +: DATA_WIDTH]),
      .read_busy     (rd_busy_s[i])
    );
  end

  // Outputs are forced to zero while reset is held, so a bypassed write
  // cannot leak through during reset.
  always_comb begin
    if (RESET) begin
      bus.READ_DATA = rd_data_s;
      bus.READ_BUSY = rd_busy_s;
    end else begin
      bus.READ_DATA = {(NUM_READ*DATA_WIDTH){1'b0}};
      bus.READ_BUSY = {NUM_READ{1'b0}};
    end
  end

endmodule
